// File: rtl/rgb_pwm_blink.sv
// Three-channel LED PWM driver with off/solid/blink/breathe modes.
// Config writes are shadowed and take effect only at PWM period boundaries.
module rgb_pwm_blink #(
   parameter int unsigned PWM_BITS    = 8,
   parameter int unsigned TICK_DIV    = 12000,
   parameter int unsigned BLINK_TICKS = 500,
   parameter bit          ACTIVE_LOW  = 1'b1
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                cfg_we,
   input  logic [1:0]          cfg_mode,
   input  logic [PWM_BITS-1:0] cfg_r,
   input  logic [PWM_BITS-1:0] cfg_g,
   input  logic [PWM_BITS-1:0] cfg_b,
   output logic                cfg_pending,
   output logic                period_start,
   output logic                led_r,
   output logic                led_g,
   output logic                led_b
);

   localparam int unsigned DivW  = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam int unsigned BlkW  = $clog2(BLINK_TICKS + 1);
   localparam int unsigned ProdW = 2 * PWM_BITS;
   localparam logic [DivW-1:0]     DivMax = DivW'(TICK_DIV - 1);
   localparam logic [BlkW-1:0]     BlkMax = BlkW'(BLINK_TICKS - 1);
   localparam logic [PWM_BITS-1:0] LvlMax = '1;

   typedef enum logic [1:0] {
      ModeOff     = 2'd0,
      ModeSolid   = 2'd1,
      ModeBlink   = 2'd2,
      ModeBreathe = 2'd3
   } mode_e;

   logic [DivW-1:0]     count0_q;
   logic [PWM_BITS-1:0] pwm_cnt_q;
   logic                period_start_q;
   logic                cfg_pending_q;
   mode_e               act_mode_q, pend_mode_q, new_mode;
   logic [PWM_BITS-1:0] act_col_q [3];
   logic [PWM_BITS-1:0] pend_col_q [3];
   logic [PWM_BITS-1:0] new_col [3];
   logic [PWM_BITS-1:0] cfg_col [3];
   logic [BlkW-1:0]     tick_cnt_q, tick_cnt_d;
   logic                phase_q, phase_d;
   logic [PWM_BITS-1:0] lvl_q, lvl_d, lvl_step;
   logic                dir_down_q, dir_down_d;
   logic [2:0]          led_q;
   logic [ProdW-1:0]    prod [3];
   logic [PWM_BITS-1:0] duty [3];
   logic [2:0]          lit;
   logic                tick, boundary, apply, mode_change;

   assign tick     = (count0_q == DivMax);
   assign boundary = (pwm_cnt_q == '1);

   // A write landing on the boundary bypasses the shadow and applies at once.
   always_comb begin
      cfg_col[0] = cfg_r;
      cfg_col[1] = cfg_g;
      cfg_col[2] = cfg_b;
      apply      = 1'b0;
      new_mode   = act_mode_q;
      new_col    = act_col_q;
      if (boundary) begin
         if (cfg_we) begin
            apply    = 1'b1;
            new_mode = mode_e'(cfg_mode);
            new_col  = cfg_col;
         end else if (cfg_pending_q) begin
            apply    = 1'b1;
            new_mode = pend_mode_q;
            new_col  = pend_col_q;
         end
      end
      mode_change = apply && (new_mode != act_mode_q);
   end

   always_comb begin
      tick_cnt_d = tick_cnt_q;
      phase_d    = phase_q;
      lvl_d      = lvl_q;
      dir_down_d = dir_down_q;
      lvl_step   = dir_down_q ? lvl_q - 1'b1 : lvl_q + 1'b1;
      if (act_mode_q != ModeBlink) begin
         tick_cnt_d = '0;
         phase_d    = 1'b0;
      end else if (tick) begin
         if (tick_cnt_q == BlkMax) begin
            tick_cnt_d = '0;
            phase_d    = ~phase_q;
         end else begin
            tick_cnt_d = tick_cnt_q + 1'b1;
         end
      end
      // Direction flips on arrival at an endpoint, so each endpoint lasts one tick.
      if (act_mode_q != ModeBreathe) begin
         lvl_d      = '0;
         dir_down_d = 1'b0;
      end else if (tick) begin
         lvl_d = lvl_step;
         if (lvl_step == LvlMax) begin
            dir_down_d = 1'b1;
         end else if (lvl_step == '0) begin
            dir_down_d = 1'b0;
         end
      end
      if (mode_change) begin
         tick_cnt_d = '0;
         phase_d    = 1'b0;
         lvl_d      = '0;
         dir_down_d = 1'b0;
      end
   end

   always_comb begin
      lit = '0;
      for (int i = 0; i < 3; i++) begin
         prod[i] = ProdW'(act_col_q[i]) * ProdW'(lvl_q);
         duty[i] = '0;
         unique case (act_mode_q)
            ModeOff:     duty[i] = '0;
            ModeSolid:   duty[i] = act_col_q[i];
            ModeBlink:   duty[i] = phase_q ? '0 : act_col_q[i];
            ModeBreathe: duty[i] = prod[i][ProdW-1:PWM_BITS];
         endcase
         lit[i] = (pwm_cnt_q < duty[i]);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         count0_q       <= '0;
         pwm_cnt_q      <= '0;
         period_start_q <= 1'b0;
         cfg_pending_q  <= 1'b0;
         act_mode_q     <= ModeOff;
         pend_mode_q    <= ModeOff;
         for (int i = 0; i < 3; i++) begin
            act_col_q[i]  <= '0;
            pend_col_q[i] <= '0;
         end
         tick_cnt_q     <= '0;
         phase_q        <= 1'b0;
         lvl_q          <= '0;
         dir_down_q     <= 1'b0;
         led_q          <= {3{ACTIVE_LOW}};
      end else begin
         count0_q       <= tick ? '0 : count0_q + 1'b1;
         pwm_cnt_q      <= pwm_cnt_q + 1'b1;
         period_start_q <= boundary;
         if (apply) begin
            act_mode_q <= new_mode;
            act_col_q  <= new_col;
         end
         if (boundary) begin
            cfg_pending_q <= 1'b0;
         end else if (cfg_we) begin
            cfg_pending_q <= 1'b1;
            pend_mode_q   <= mode_e'(cfg_mode);
            pend_col_q    <= cfg_col;
         end
         tick_cnt_q     <= tick_cnt_d;
         phase_q        <= phase_d;
         lvl_q          <= lvl_d;
         dir_down_q     <= dir_down_d;
         led_q          <= lit ^ {3{ACTIVE_LOW}};
      end
   end

   assign cfg_pending  = cfg_pending_q;
   assign period_start = period_start_q;
   assign led_r        = led_q[0];
   assign led_g        = led_q[1];
   assign led_b        = led_q[2];

endmodule

// File: tb/tb_rgb_pwm_blink.sv
// Bench for rgb_pwm_blink: directed scenarios plus random config traffic, checked
// every cycle against a time-based model (PWM_BITS=4, TICK_DIV=4, BLINK_TICKS=3).
module tb_rgb_pwm_blink;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       cfg_we = 1'b0;
   logic [1:0] cfg_mode = '0;
   logic [3:0] cfg_r = '0, cfg_g = '0, cfg_b = '0;
   logic       cfg_pending, period_start, led_r, led_g, led_b;

   int checks = 0;
   int failures = 0;

   always #5 clk = ~clk;

   rgb_pwm_blink #(
      .PWM_BITS   (4),
      .TICK_DIV   (4),
      .BLINK_TICKS(3),
      .ACTIVE_LOW (1'b1)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .cfg_we      (cfg_we),
      .cfg_mode    (cfg_mode),
      .cfg_r       (cfg_r),
      .cfg_g       (cfg_g),
      .cfg_b       (cfg_b),
      .cfg_pending (cfg_pending),
      .period_start(period_start),
      .led_r       (led_r),
      .led_g       (led_g),
      .led_b       (led_b)
   );

   // Model: k = cycles since reset; the mode's animation time is ticks elapsed since
   // the state index at which the current mode was entered.
   int         k = 0, mode_start = 0, m_mode = 0, p_mode = 0;
   int         m_col [3] = '{0, 0, 0};
   int         p_col [3] = '{0, 0, 0};
   bit         m_pend = 0;
   logic [2:0] exp_leds = 3'b111;
   logic       exp_ps = 1'b0, exp_pend = 1'b0;

   function automatic int m_ticks(int kk);
      return kk / 4 - mode_start / 4;
   endfunction

   function automatic int m_lvl(int kk);
      int p;
      p = m_ticks(kk) % 30;
      return (p <= 15) ? p : 30 - p;
   endfunction

   function automatic int m_duty(int ch, int kk);
      case (m_mode)
         0:       return 0;
         1:       return m_col[ch];
         2:       return ((m_ticks(kk) / 3) % 2 == 1) ? 0 : m_col[ch];
         default: return (m_col[ch] * m_lvl(kk)) >> 4;
      endcase
   endfunction

   always @(posedge clk) begin
      if (rst) begin
         k = 0; mode_start = 0; m_mode = 0; m_pend = 0;
         m_col = '{0, 0, 0};
         exp_leds = 3'b111; exp_ps = 1'b0; exp_pend = 1'b0;
      end else begin
         for (int ch = 0; ch < 3; ch++) exp_leds[2-ch] = !((k % 16) < m_duty(ch, k));
         exp_ps = (k % 16 == 15);
         if (k % 16 == 15) begin
            if (cfg_we) begin
               if (int'(cfg_mode) != m_mode) mode_start = k + 1;
               m_mode = int'(cfg_mode);
               m_col = '{int'(cfg_r), int'(cfg_g), int'(cfg_b)};
            end else if (m_pend) begin
               if (p_mode != m_mode) mode_start = k + 1;
               m_mode = p_mode;
               m_col = p_col;
            end
            m_pend = 0;
         end else if (cfg_we) begin
            p_mode = int'(cfg_mode);
            p_col = '{int'(cfg_r), int'(cfg_g), int'(cfg_b)};
            m_pend = 1;
         end
         k++;
         exp_pend = m_pend;
      end
   end

   task automatic set_cfg(input int mode, input int r, input int g, input int b);
      cfg_we = 1'b1;
      cfg_mode = 2'(mode);
      cfg_r = 4'(r); cfg_g = 4'(g); cfg_b = 4'(b);
   endtask

   task automatic test_reset();
      int n;
      rst = 1'b1;
      repeat (5) @(negedge clk);
      checks++;
      if ({led_r, led_g, led_b} !== 3'b111) begin
         failures++; $display("FAIL reset_leds: got %b want 111", {led_r, led_g, led_b});
      end
      checks++;
      if (cfg_pending !== 1'b0 || period_start !== 1'b0) begin
         failures++; $display("FAIL reset_flags: got pend=%b ps=%b want 0 0", cfg_pending, period_start);
      end
      rst = 1'b0;
      n = 0;
      for (int i = 1; i <= 40; i++) begin
         @(negedge clk);
         checks++;
         if ({led_r, led_g, led_b, period_start, cfg_pending} !== {exp_leds, exp_ps, exp_pend}) begin
            failures++; $display("FAIL reset_cycle k=%0d: got %b want %b", k,
               {led_r, led_g, led_b, period_start, cfg_pending}, {exp_leds, exp_ps, exp_pend});
         end
         if (period_start) begin n = i; break; end
      end
      checks++;
      if (n !== 16) begin
         failures++; $display("FAIL first_period_start: got %0d clks want 16", n);
      end
   endtask

   // Runs until period_start (bounded), checking each cycle against the model.
   task automatic wait_period(input string name);
      bit seen;
      seen = 0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         checks++;
         if ({led_r, led_g, led_b, period_start, cfg_pending} !== {exp_leds, exp_ps, exp_pend}) begin
            failures++; $display("FAIL %s_cycle k=%0d: got %b want %b", name, k,
               {led_r, led_g, led_b, period_start, cfg_pending}, {exp_leds, exp_ps, exp_pend});
         end
         cfg_we = 1'b0;
         if (period_start) begin seen = 1; break; end
      end
      checks++;
      if (!seen) begin
         failures++; $display("FAIL %s_boundary: got no period_start want one within 20 clks", name);
      end
   endtask

   task automatic test_solid();
      int lr, lg, lb;
      set_cfg(1, 5, 0, 15);
      wait_period("solid");
      for (int p = 0; p < 2; p++) begin
         lr = 0; lg = 0; lb = 0;
         repeat (16) begin
            @(negedge clk);
            checks++;
            if ({led_r, led_g, led_b, period_start, cfg_pending} !== {exp_leds, exp_ps, exp_pend}) begin
               failures++; $display("FAIL solid_cycle k=%0d: got %b want %b", k,
                  {led_r, led_g, led_b, period_start, cfg_pending}, {exp_leds, exp_ps, exp_pend});
            end
            lr += int'(!led_r); lg += int'(!led_g); lb += int'(!led_b);
         end
         checks++;
         if (lr != 5 || lg != 0 || lb != 15) begin
            failures++; $display("FAIL solid_duty: got r=%0d g=%0d b=%0d want 5 0 15", lr, lg, lb);
         end
      end
   endtask

   task automatic test_shadow();
      int lr, lg;
      repeat (3) @(negedge clk);
      set_cfg(1, 3, 0, 0);
      @(negedge clk);
      cfg_we = 1'b0;
      checks++;
      if (cfg_pending !== 1'b1) begin
         failures++; $display("FAIL shadow_pending: got %b want 1", cfg_pending);
      end
      repeat (2) @(negedge clk);
      set_cfg(1, 9, 0, 0);
      wait_period("shadow");
      checks++;
      if (cfg_pending !== 1'b0) begin
         failures++; $display("FAIL shadow_applied: got pending=%b want 0", cfg_pending);
      end
      lr = 0;
      repeat (16) begin
         @(negedge clk);
         lr += int'(!led_r);
      end
      checks++;
      if (lr != 9) begin
         failures++; $display("FAIL shadow_last_wins: got red duty %0d want 9", lr);
      end
      repeat (15) @(negedge clk);
      set_cfg(1, 12, 3, 0);
      @(negedge clk);
      cfg_we = 1'b0;
      checks++;
      if (period_start !== 1'b1 || cfg_pending !== 1'b0) begin
         failures++; $display("FAIL shadow_on_boundary: got ps=%b pend=%b want 1 0",
            period_start, cfg_pending);
      end
      lr = 0; lg = 0;
      repeat (16) begin
         @(negedge clk);
         lr += int'(!led_r); lg += int'(!led_g);
      end
      checks++;
      if (lr != 12 || lg != 3) begin
         failures++; $display("FAIL shadow_immediate: got r=%0d g=%0d want 12 3", lr, lg);
      end
   endtask

   // After a mode switch into blink, red (level 15) lights for 12 clks then goes dark for 12.
   task automatic check_blink_start(input string name);
      int on_lows, off_lows;
      on_lows = 0; off_lows = 0;
      for (int i = 0; i < 24; i++) begin
         @(negedge clk);
         checks++;
         if ({led_r, led_g, led_b, period_start, cfg_pending} !== {exp_leds, exp_ps, exp_pend}) begin
            failures++; $display("FAIL %s_cycle k=%0d: got %b want %b", name, k,
               {led_r, led_g, led_b, period_start, cfg_pending}, {exp_leds, exp_ps, exp_pend});
         end
         if (i < 12) on_lows += int'(!led_r);
         else off_lows += int'(!led_r);
      end
      checks++;
      if (on_lows != 12 || off_lows != 0) begin
         failures++; $display("FAIL %s_phase: got lit=%0d dark-lit=%0d want 12 0", name,
            on_lows, off_lows);
      end
   endtask

   task automatic test_blink();
      set_cfg(2, 15, 0, 0);
      wait_period("blink");
      check_blink_start("blink");
      repeat (100) begin
         @(negedge clk);
         checks++;
         if ({led_r, led_g, led_b, period_start, cfg_pending} !== {exp_leds, exp_ps, exp_pend}) begin
            failures++; $display("FAIL blink_cycle k=%0d: got %b want %b", k,
               {led_r, led_g, led_b, period_start, cfg_pending}, {exp_leds, exp_ps, exp_pend});
         end
      end
   endtask

   task automatic test_breathe();
      set_cfg(3, 15, 8, 1);
      wait_period("breathe");
      repeat (260) begin
         @(negedge clk);
         checks++;
         if ({led_r, led_g, led_b, period_start, cfg_pending} !== {exp_leds, exp_ps, exp_pend}) begin
            failures++; $display("FAIL breathe_cycle k=%0d lvl=%0d: got %b want %b", k, m_lvl(k),
               {led_r, led_g, led_b, period_start, cfg_pending}, {exp_leds, exp_ps, exp_pend});
         end
      end
   endtask

   task automatic test_reset_mid();
      bit hit;
      int lows;
      hit = 0;
      for (int i = 0; i < 200; i++) begin
         @(negedge clk);
         if (m_lvl(k) == 7) begin hit = 1; break; end
      end
      checks++;
      if (!hit) begin
         failures++; $display("FAIL reset_mid_lvl: got no lvl 7 want lvl 7 within 200 clks");
      end
      rst = 1'b1;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      checks++;
      if ({led_r, led_g, led_b, cfg_pending} !== 4'b1110) begin
         failures++; $display("FAIL reset_mid_state: got %b want 1110",
            {led_r, led_g, led_b, cfg_pending});
      end
      lows = 0;
      repeat (40) begin
         @(negedge clk);
         checks++;
         if ({led_r, led_g, led_b, period_start, cfg_pending} !== {exp_leds, exp_ps, exp_pend}) begin
            failures++; $display("FAIL reset_mid_cycle k=%0d: got %b want %b", k,
               {led_r, led_g, led_b, period_start, cfg_pending}, {exp_leds, exp_ps, exp_pend});
         end
         lows += int'(!led_r) + int'(!led_g) + int'(!led_b);
      end
      checks++;
      if (lows != 0) begin
         failures++; $display("FAIL reset_mid_dark: got %0d lit samples want 0", lows);
      end
      set_cfg(3, 15, 0, 0);
      wait_period("switch_breathe");
      repeat (50) @(negedge clk);
      set_cfg(2, 15, 0, 0);
      wait_period("switch_blink");
      check_blink_start("switch");
   endtask

   task automatic test_random();
      repeat (600) begin
         @(negedge clk);
         if (!rst) begin
            checks++;
            if ({led_r, led_g, led_b, period_start, cfg_pending} !== {exp_leds, exp_ps, exp_pend}) begin
               failures++; $display("FAIL random_cycle k=%0d: got %b want %b", k,
                  {led_r, led_g, led_b, period_start, cfg_pending}, {exp_leds, exp_ps, exp_pend});
            end
         end
         cfg_we = 1'b0;
         rst = 1'b0;
         if ($urandom_range(0, 7) == 0)
            set_cfg(int'($urandom_range(0, 3)), int'($urandom_range(0, 15)),
                    int'($urandom_range(0, 15)), int'($urandom_range(0, 15)));
         if ($urandom_range(0, 149) == 0) rst = 1'b1;
      end
      cfg_we = 1'b0;
      rst = 1'b0;
      repeat (2) @(negedge clk);
   endtask

   initial begin
      test_reset();
      test_solid();
      test_shadow();
      test_blink();
      test_breathe();
      test_reset_mid();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
